deserializador: RTL and testbench
=================================

DESERIALIZADOR -- requirements
Module: deserializador

Interface
REQ-001 The module SHALL have one clock and a reset that is synchronous and active-high; the clock port SHALL be named clk_100KHz and the reset port SHALL be named reset.
REQ-002 Parameter: WORD_W, default 8, bits per assembled word. Only the default value is required to be supported.
REQ-003 clk_100KHz  input  1  system clock; all state SHALL update on the rising edge only.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 data_in  input  1  serial data bit, sampled only when write_in=1.
REQ-006 write_in  input  1  qualifies data_in; each clock edge with write_in=1 is one bit.
REQ-007 ack_in  input  1  consumer acknowledge of the presented word.
REQ-008 status_out  output  1  busy/full flag; 1 means a word is pending and serial input is refused.
REQ-009 data_out  output  8  last completed parallel word.
REQ-010 data_ready  output  1  data_out holds an unacknowledged word.

Function
REQ-011 The FSM SHALL have two states: RECEIVE and READY.
REQ-012 In RECEIVE, each edge with write_in=1 SHALL shift data_in into an internal shift register and increment a 3-bit bit counter.
REQ-013 Default bit order SHALL be MSB-first: the first received bit ends in data_out[7] and the eighth in data_out[0].
REQ-014 On the edge that samples the 8th bit, the module SHALL load data_out with the full word, set data_ready=1 and status_out=1, clear the counter, and enter READY. The outputs are registered and change on that same edge, so there is zero added latency after the 8th bit.
REQ-015 In RECEIVE, edges with write_in=0 SHALL leave the counter and shift register unchanged, so gaps between bits are allowed.
REQ-016 In READY, write_in and data_in SHALL be ignored; such bits are dropped and not buffered.
REQ-017 In READY, an edge with ack_in=1 SHALL clear data_ready and status_out and return to RECEIVE.
REQ-018 If write_in=1 and ack_in=1 on the same edge in READY, the ack SHALL be processed and the bit SHALL be dropped.
REQ-019 ack_in in RECEIVE SHALL have no effect.
REQ-020 data_out SHALL hold its value after an ack until the next word completes; partial words SHALL never appear on data_out.
REQ-021 status_out SHALL always equal data_ready.
REQ-022 Partial words SHALL persist indefinitely; there is no timeout.

Reset
REQ-023 With reset=1 at an edge, the module SHALL set data_out=8'h00, data_ready=0, status_out=0, shift register=0, counter=0 and state=RECEIVE.
REQ-024 Reset SHALL take priority over write_in and ack_in.
REQ-025 Reset asserted mid-word or in READY SHALL discard all partial or pending data.
REQ-026 Reset SHALL have no asynchronous effect.

Configuration
REQ-027 Macro DESERI_LSB_FIRST_EN: when defined, the first received bit SHALL land in data_out[0] and the eighth in data_out[7]. When undefined, MSB-first per REQ-013 applies. All other behaviour is identical in both builds.

Verification
REQ-028 Reset, then send bits 1,0,1,0,0,1,0,1 on consecutive edges with write_in=1 -> after the 8th edge data_out=8'hA5, data_ready=1, status_out=1.
REQ-029 Same 8 bits with write_in=0 gaps of 3 cycles between bits -> data_out=8'hA5 only after the 8th bit, and data_ready=0 before it.
REQ-030 In READY, send 4 extra bits, then pulse ack_in for 1 cycle -> data_out stays 8'hA5 and data_ready/status_out=0 on the next edge; then a new word 8'h3C -> data_out=8'h3C (the extra bits did not corrupt it).
REQ-031 Send 5 bits, assert reset for 1 cycle, then send 8'hFF -> data_out=8'hFF, with no leftover bits.
REQ-032 In READY, write_in=1 and ack_in=1 on the same edge, then 8 more bits of 8'h81 -> data_out=8'h81.
REQ-033 Build with DESERI_LSB_FIRST_EN and send bit sequence 1,0,1,0,0,1,0,1 -> data_out=8'hA5 under the REQ-027 mapping; the same sequence MSB-first also yields 8'hA5, so sequence 1,0,0,0,0,0,0,0 SHALL give 8'h01 with the macro and 8'h80 without it.

Source files
------------

// File: rtl/deserializador.sv
// ============================================================================
// Module   : deserializador
// Purpose  : Serial-to-parallel word assembler with ready/ack handshake.
//            Define DESERI_LSB_FIRST_EN for LSB-first assembly (default MSB-first).
// Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module deserializador #(
   parameter int WORD_W = 8
) (
   input  logic              clk_100KHz,
   input  logic              reset,
   input  logic              data_in,
   input  logic              write_in,
   input  logic              ack_in,
   output logic              status_out,
   output logic [WORD_W-1:0] data_out,
   output logic              data_ready
);

   localparam int CNT_W = $clog2(WORD_W);
   localparam logic [CNT_W-1:0] C_LAST_BIT = CNT_W'(WORD_W - 1);

   typedef enum logic [0:0] {
      RECEIVE = 1'b0,
      READY   = 1'b1
   } state_t;

   state_t            state_q, state_d;
   logic [WORD_W-1:0] shift_q, shift_d;
   logic [CNT_W-1:0]  cnt_q,   cnt_d;
   logic [WORD_W-1:0] data_q,  data_d;
   logic              ready_q, ready_d;
   logic [WORD_W-1:0] shift_next;

   // Shift direction decides where the first received bit finally lands.
`ifdef DESERI_LSB_FIRST_EN
   assign shift_next = {data_in, shift_q[WORD_W-1:1]};
`else
   assign shift_next = {shift_q[WORD_W-2:0], data_in};
`endif

   always_comb begin
      state_d = state_q;
      shift_d = shift_q;
      cnt_d   = cnt_q;
      data_d  = data_q;
      ready_d = ready_q;
      case (state_q)
         RECEIVE: begin
            if (write_in) begin
               if (cnt_q == C_LAST_BIT) begin
                  data_d  = shift_next;
                  ready_d = 1'b1;
                  shift_d = '0;
                  cnt_d   = '0;
                  state_d = READY;
               end else begin
                  shift_d = shift_next;
                  cnt_d   = cnt_q + 1'b1;
               end
            end
         end
         READY: begin
            // Serial bits arriving while a word is pending are dropped.
            if (ack_in) begin
               ready_d = 1'b0;
               state_d = RECEIVE;
            end
         end
         default: state_d = RECEIVE;
      endcase
   end

   always_ff @(posedge clk_100KHz) begin
      if (reset) begin
         state_q <= RECEIVE;
         shift_q <= '0;
         cnt_q   <= '0;
         data_q  <= '0;
         ready_q <= 1'b0;
      end else begin
         state_q <= state_d;
         shift_q <= shift_d;
         cnt_q   <= cnt_d;
         data_q  <= data_d;
         ready_q <= ready_d;
      end
   end

   assign data_out   = data_q;
   assign data_ready = ready_q;
   assign status_out = ready_q;

endmodule

`default_nettype wire

// File: tb/tb_deserializador.sv
// ============================================================================
// Module   : tb_deserializador
// Purpose  : Directed and random checks of deserializador against a queue model.
// Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_deserializador;

   logic       clk_100KHz = 1'b0;
   logic       reset      = 1'b1;
   logic       data_in    = 1'b0;
   logic       write_in   = 1'b0;
   logic       ack_in     = 1'b0;
   logic       status_out;
   logic [7:0] data_out;
   logic       data_ready;

   int checks = 0;
   int errors = 0;

   // Reference model: collected bits in arrival order plus the presented word.
   bit         m_bits[$];
   logic [7:0] m_data  = 8'h00;
   logic       m_ready = 1'b0;

   deserializador #(.WORD_W(8)) dut (
      .clk_100KHz (clk_100KHz),
      .reset      (reset),
      .data_in    (data_in),
      .write_in   (write_in),
      .ack_in     (ack_in),
      .status_out (status_out),
      .data_out   (data_out),
      .data_ready (data_ready)
   );

   always #5 clk_100KHz = ~clk_100KHz;

   function automatic logic [7:0] assemble();
      logic [7:0] w;
      w = 8'h00;
      for (int i = 0; i < 8; i++) begin
`ifdef DESERI_LSB_FIRST_EN
         w[i] = m_bits[i];
`else
         w[7-i] = m_bits[i];
`endif
      end
      return w;
   endfunction

   task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
      checks++;
      assert (got === exp) else begin
         errors++;
         $error("FAIL %s: observed=%h expected=%h", tag, got, exp);
      end
   endtask

   task automatic step(input logic w, input logic d, input logic a, input logic r);
      @(negedge clk_100KHz);
      write_in = w;
      data_in  = d;
      ack_in   = a;
      reset    = r;
      @(posedge clk_100KHz);
      if (r) begin
         m_bits.delete();
         m_ready = 1'b0;
         m_data  = 8'h00;
      end else if (m_ready) begin
         if (a) m_ready = 1'b0;
      end else if (w) begin
         m_bits.push_back(d);
         if (m_bits.size() == 8) begin
            m_data  = assemble();
            m_ready = 1'b1;
            m_bits.delete();
         end
      end
      #1;
      chk("data_out",   data_out,          m_data);
      chk("data_ready", {7'd0, data_ready}, {7'd0, m_ready});
      chk("status_out", {7'd0, status_out}, {7'd0, m_ready});
   endtask

   // Sends w[7] first; each bit is followed by 'gap' idle cycles except the last.
   task automatic send_word(input logic [7:0] w, input int gap);
      for (int i = 7; i >= 0; i--) begin
         step(1'b1, w[i], 1'b0, 1'b0);
         if (i > 0)
            for (int g = 0; g < gap; g++) step(1'b0, 1'b0, 1'b0, 1'b0);
      end
   endtask

   initial begin
      logic [7:0] pat;

      step(1'b0, 1'b0, 1'b0, 1'b1);
      chk("reset_data",  data_out, 8'h00);
      chk("reset_ready", {7'd0, data_ready}, 8'h00);

      // Back-to-back A5 (palindromic, same result in both bit orders)
      send_word(8'hA5, 0);
      chk("a5_word",  data_out, 8'hA5);
      chk("a5_ready", {7'd0, data_ready}, 8'h01);
      chk("a5_busy",  {7'd0, status_out}, 8'h01);

      // Dropped bits while READY, then ack
      for (int i = 0; i < 4; i++) step(1'b1, i[0], 1'b0, 1'b0);
      chk("ready_hold", data_out, 8'hA5);
      step(1'b0, 1'b0, 1'b1, 1'b0);
      chk("ack_hold",  data_out, 8'hA5);
      chk("ack_clear", {7'd0, data_ready}, 8'h00);
      send_word(8'h3C, 0);
      chk("w3c", data_out, 8'h3C);
      step(1'b0, 1'b0, 1'b1, 1'b0);

      // Gapped A5: no ready before 8th bit
      pat = 8'hA5;
      for (int i = 7; i >= 1; i--) begin
         step(1'b1, pat[i], 1'b0, 1'b0);
         for (int g = 0; g < 3; g++) step(1'b0, 1'b0, 1'b1, 1'b0);
      end
      chk("gap_not_ready", {7'd0, data_ready}, 8'h00);
      chk("gap_old_word",  data_out, 8'h3C);
      step(1'b1, pat[0], 1'b0, 1'b0);
      chk("gap_word", data_out, 8'hA5);

      // Simultaneous write+ack in READY, then 81
      step(1'b1, 1'b1, 1'b1, 1'b0);
      chk("wa_clear", {7'd0, data_ready}, 8'h00);
      send_word(8'h81, 0);
      chk("w81", data_out, 8'h81);
      step(1'b0, 1'b0, 1'b1, 1'b0);

      // Partial word then reset, then FF
      for (int i = 0; i < 5; i++) step(1'b1, 1'b0, 1'b0, 1'b0);
      step(1'b1, 1'b0, 1'b1, 1'b1);
      chk("rst_mid", data_out, 8'h00);
      send_word(8'hFF, 0);
      chk("wff", data_out, 8'hFF);
      step(1'b0, 1'b0, 1'b1, 1'b0);

      // Bit-order discriminator
      send_word(8'h80, 1);
`ifdef DESERI_LSB_FIRST_EN
      chk("order", data_out, 8'h01);
`else
      chk("order", data_out, 8'h80);
`endif
      step(1'b0, 1'b0, 1'b1, 1'b0);

      // Random traffic against the model
      for (int n = 0; n < 600; n++) begin
         step(($urandom_range(0, 9) < 6),
              1'($urandom),
              ($urandom_range(0, 9) < 2),
              ($urandom_range(0, 99) < 2));
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

`default_nettype wire
